// File: rtl/regwr_arbiter_if.sv
// Bundle of requester handshakes, busy hints and register-file write ports for regwr_arbiter.
// The requester side uses the master modport; the arbiter uses slave.
interface regwr_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ADDRW = 5
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*32-1:0]    req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  st_busy;
    logic                  pc_busy;
    logic [1:0]            write;
    logic [ADDRW-1:0]      wa0;
    logic [ADDRW-1:0]      wa1;
    logic [31:0]           wd0;
    logic [31:0]           wd1;
    logic [NREQ-1:0]       starve;

    modport master (
        output req_valid, req_addr, req_data, st_busy, pc_busy,
        input  req_ready, write, wa0, wa1, wd0, wd1, starve
    );

    modport slave (
        input  req_valid, req_addr, req_data, st_busy, pc_busy,
        output req_ready, write, wa0, wa1, wd0, wd1, starve
    );
endinterface

// File: rtl/regwr_arbiter.sv
// Two-port register-file write arbiter: round-robin over NREQ requesters, with a
// starvation override on port 0 and same-address suppression on port 1.
module regwr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ADDRW = 5
) (
    input logic           clk,
    input logic           rst,
    regwr_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDRW-1:0] StAddr = ADDRW'(28);
    localparam logic [ADDRW-1:0] PcAddr = ADDRW'(31);

    logic [ADDRW-1:0] addr_a [NREQ];
    logic [31:0]      data_a [NREQ];
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  ready;
    logic             g0, g1;
    logic [PW-1:0]    p0, p1;

    logic [1:0]            write_q, write_d;
    logic [ADDRW-1:0]      wa0_q, wa0_d, wa1_q, wa1_d;
    logic [31:0]           wd0_q, wd0_d, wd1_q, wd1_d;
    logic [PW-1:0]         rr_q, rr_d;
    logic [NREQ-1:0][3:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]       starve_q, starve_d;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = bus.req_addr[i*ADDRW +: ADDRW];
            data_a[i] = bus.req_data[i*32 +: 32];
            elig[i]   = bus.req_valid[i] && !rst
                        && !(addr_a[i] == StAddr && bus.st_busy)
                        && !(addr_a[i] == PcAddr && bus.pc_busy);
        end
    end

    // Port 0: lowest-index starving eligible requester, else first eligible from rr_q.
    // Port 1: next eligible after port 0 whose address differs.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        g0    = 1'b0;
        g1    = 1'b0;
        p0    = '0;
        p1    = '0;
        ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!g0 && elig[i] && starve_q[i]) begin
                g0 = 1'b1;
                p0 = PW'(i);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_q) + k) % NREQ;
            if (!g0 && elig[idx]) begin
                g0 = 1'b1;
                p0 = PW'(idx);
            end
        end
        for (int unsigned k = 1; k < NREQ; k++) begin
            idx = (32'(p0) + k) % NREQ;
            if (g0 && !g1 && elig[idx] && addr_a[idx] != addr_a[p0]) begin
                g1 = 1'b1;
                p1 = PW'(idx);
            end
        end
        if (g0) ready[p0] = 1'b1;
        if (g1) ready[p1] = 1'b1;
    end

    always_comb begin
        write_d = {g1, g0};
        wa0_d   = g0 ? addr_a[p0] : wa0_q;
        wd0_d   = g0 ? data_a[p0] : wd0_q;
        wa1_d   = g1 ? addr_a[p1] : wa1_q;
        wd1_d   = g1 ? data_a[p1] : wd1_q;
        rr_d    = rr_q;
        if (g1) begin
            rr_d = PW'((32'(p1) + 1) % NREQ);
        end else if (g0) begin
            rr_d = PW'((32'(p0) + 1) % NREQ);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i] && !ready[i]) begin
                cnt_d[i] = (cnt_q[i] == 4'd15) ? 4'd15 : cnt_q[i] + 4'd1;
            end else begin
                cnt_d[i] = 4'd0;
            end
            starve_d[i] = (cnt_d[i] == 4'd15);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q  <= '0;
            wa0_q    <= '0;
            wa1_q    <= '0;
            wd0_q    <= '0;
            wd1_q    <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
        end else begin
            write_q  <= write_d;
            wa0_q    <= wa0_d;
            wa1_q    <= wa1_d;
            wd0_q    <= wd0_d;
            wd1_q    <= wd1_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.write     = write_q;
    assign bus.wa0       = wa0_q;
    assign bus.wa1       = wa1_q;
    assign bus.wd0       = wd0_q;
    assign bus.wd1       = wd1_q;
    assign bus.starve    = starve_q;
endmodule

// File: tb/tb_regwr_arbiter.sv
// Randomized bench for regwr_arbiter against a behavioural model of the grant rules,
// with busy phases long enough to provoke starvation and occasional reset pulses.
module tb_regwr_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned ADDRW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regwr_arbiter_if #(.NREQ(NREQ), .ADDRW(ADDRW)) bus ();
    regwr_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Requester state driven onto the bus
    bit          v_m [NREQ];
    int          a_m [NREQ];
    logic [31:0] d_m [NREQ];
    bit          st_b, pc_b;

    // Model state and expected outputs
    int              rr_m;
    int              wait_m [NREQ];
    bit [NREQ-1:0]   rdy_m;
    bit [1:0]        wr_m;
    int              wa0_m, wa1_m;
    logic [31:0]     wd0_m, wd1_m;
    bit [NREQ-1:0]   stv_m;

    function automatic bit eligible(int i);
        return v_m[i] && !(a_m[i] == 28 && st_b) && !(a_m[i] == 31 && pc_b);
    endfunction

    task automatic model_step(input bit r);
        int p0, p1, idx;
        int q[$];
        rdy_m = '0;
        if (r) begin
            wr_m  = 2'b00;
            wa0_m = 0; wa1_m = 0;
            wd0_m = '0; wd1_m = '0;
            rr_m  = 0;
            stv_m = '0;
            for (int i = 0; i < NREQ; i++) wait_m[i] = 0;
            return;
        end
        p0 = -1;
        p1 = -1;
        for (int i = 0; i < NREQ; i++)
            if (p0 < 0 && wait_m[i] == 15 && eligible(i)) p0 = i;
        if (p0 < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (rr_m + k) % NREQ;
                if (eligible(idx)) q.push_back(idx);
            end
            if (q.size() > 0) p0 = q[0];
        end
        if (p0 >= 0) begin
            for (int k = 1; k < NREQ; k++) begin
                idx = (p0 + k) % NREQ;
                if (p1 < 0 && eligible(idx) && a_m[idx] != a_m[p0]) p1 = idx;
            end
        end
        wr_m = {p1 >= 0, p0 >= 0};
        if (p0 >= 0) begin
            rdy_m[p0] = 1'b1;
            wa0_m = a_m[p0];
            wd0_m = d_m[p0];
            rr_m  = (((p1 >= 0) ? p1 : p0) + 1) % NREQ;
        end
        if (p1 >= 0) begin
            rdy_m[p1] = 1'b1;
            wa1_m = a_m[p1];
            wd1_m = d_m[p1];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (v_m[i] && !rdy_m[i]) wait_m[i] = (wait_m[i] >= 15) ? 15 : wait_m[i] + 1;
            else                     wait_m[i] = 0;
            stv_m[i] = (wait_m[i] == 15);
        end
    endtask

    task automatic new_request(input int i, input bit hot31);
        int sel;
        v_m[i] = ($urandom_range(0, 3) != 0);
        sel    = $urandom_range(0, 7);
        case (sel)
            0:       a_m[i] = 3;
            1:       a_m[i] = 7;
            2:       a_m[i] = 28;
            3:       a_m[i] = 31;
            default: a_m[i] = $urandom_range(0, 31);
        endcase
        if (hot31 && $urandom_range(0, 1) == 1) a_m[i] = 31;
        d_m[i] = $urandom;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]                  = v_m[i];
            bus.req_addr[i*ADDRW +: ADDRW]    = ADDRW'(a_m[i]);
            bus.req_data[i*32 +: 32]          = d_m[i];
        end
        bus.st_busy = st_b;
        bus.pc_busy = pc_b;
    endtask

    initial begin
        bit r;
        bit pc_phase, st_phase;
        for (int i = 0; i < NREQ; i++) begin
            v_m[i] = 1'b0;
            a_m[i] = 0;
            d_m[i] = '0;
        end
        st_b = 1'b0;
        pc_b = 1'b0;
        drive();
        model_step(1'b1);
        repeat (2) @(posedge clk);

        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            check_eq("write",  bus.write,  wr_m);
            check_eq("wa0",    bus.wa0,    wa0_m);
            check_eq("wa1",    bus.wa1,    wa1_m);
            check_eq("wd0",    bus.wd0,    wd0_m);
            check_eq("wd1",    bus.wd1,    wd1_m);
            check_eq("starve", bus.starve, stv_m);

            pc_phase = (cyc >= 200 && cyc <= 240) || (cyc >= 600 && cyc <= 625);
            st_phase = (cyc >= 400 && cyc <= 430);
            r = (cyc == 0) || ($urandom_range(0, 59) == 0);
            // Held requests stay untouched until granted
            for (int i = 0; i < NREQ; i++)
                if (rdy_m[i] || !v_m[i]) new_request(i, pc_phase);
            pc_b = pc_phase ? 1'b1 : ($urandom_range(0, 3) == 0);
            st_b = st_phase ? 1'b1 : ($urandom_range(0, 3) == 0);
            rst  = r;
            drive();
            #1;
            model_step(r);
            check_eq("req_ready", bus.req_ready, rdy_m);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/regwr_arbiter.md
REGWR_ARBITER -- requirements
Module: regwr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of write requesters.
REQ-002 SHALL have parameter ADDRW, default 5, meaning register address width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester write request.
REQ-006 SHALL have port req_addr  input  NREQ*ADDRW  per-requester target register; requester i in bits [i*ADDRW +: ADDRW].
REQ-007 SHALL have port req_data  input  NREQ*32  per-requester write data; requester i in bits [i*32 +: 32].
REQ-008 SHALL have port req_ready  output  NREQ  grant; a transfer completes on a cycle with req_valid[i] & req_ready[i].
REQ-009 SHALL have port st_busy  input  1  status register (28) is being written by the datapath this cycle.
REQ-010 SHALL have port pc_busy  input  1  PC (31) is being incremented this cycle.
REQ-011 SHALL have port write  output  2  register-file write enables, one per port.
REQ-012 SHALL have ports wa0, wa1  output  ADDRW  write addresses for port 0 and port 1.
REQ-013 SHALL have ports wd0, wd1  output  32  write data for port 0 and port 1.
REQ-014 SHALL have port starve  output  NREQ  requester i denied for 15 or more consecutive valid cycles.

Function
REQ-015 Eligibility: a requester is eligible when req_valid=1, it is not targeting 28 while st_busy=1, and it is not targeting 31 while pc_busy=1.
REQ-016 Round-robin search order: start at rr_ptr, scan upward, wrap modulo NREQ.
REQ-017 Port 0 grant: the first eligible requester in search order.
REQ-018 Port 1 grant: the next eligible requester whose address differs from the port-0 grant.
REQ-019 Same-address requesters: only one is granted per cycle; no data merging.
REQ-020 req_ready SHALL be combinational in the same cycle and SHALL be 1 only for the at most two granted requesters.
REQ-021 write, wa0/wa1 and wd0/wd1 SHALL be registered, appearing on the cycle after the grant (latency 1).
REQ-022 An unused port SHALL drive write[k]=0; its address and data SHALL hold their previous values.
REQ-023 A lone grant SHALL always use port 0.
REQ-024 rr_ptr update: after any grant, rr_ptr <= (index of last granted requester + 1) mod NREQ; with no grant, rr_ptr is unchanged.
REQ-025 A requester with valid=1 and ready=0 SHALL hold addr and data stable; the arbiter does not sample them until grant.
REQ-026 Per-requester 4-bit wait counter: increments, saturating at 15, on each cycle valid=1 and ready=0; clears on grant or when valid=0.
REQ-027 starve[i] = (counter[i] == 15), registered.
REQ-028 A starving requester (starve[i]=1) that is eligible SHALL take port 0 regardless of rr_ptr.
REQ-029 With several starving requesters, the lowest index wins.
REQ-030 st_busy and pc_busy SHALL affect only the current cycle's eligibility; they carry no state.

Reset
REQ-031 During rst=1 the block SHALL force req_ready=0 and make no grants.
REQ-032 On a clock edge with rst=1: write=0, wa0=wa1=0, wd0=wd1=0, rr_ptr=0, all wait counters=0, starve=0.
REQ-033 rst asserted the cycle after a grant SHALL clear write on that edge, so the pending write is dropped.
REQ-034 The first grant is possible on the first cycle with rst=0.

Verification
REQ-035 Scenario: req 0 addr 3 data 0xA; req 2 addr 5 data 0xB; rr_ptr=0 -> ready=0101; next cycle write=11, wa0=3, wd0=0xA, wa1=5, wd1=0xB; rr_ptr=3.
REQ-036 Scenario: reqs 1 and 2 both target addr 7, rr_ptr=0 -> ready=0010, write=01 next cycle; following cycle ready=0100, wa0=7 with req 2 data.
REQ-037 Scenario: req 0 addr 28 with st_busy=1, req 3 addr 4 -> ready=1000 and wa0=4; drop st_busy -> req 0 granted next cycle.
REQ-038 Scenario: req 1 addr 31 with pc_busy held high for 16 cycles -> starve[1]=1 after 15 denied cycles; release pc_busy -> req 1 granted on port 0 ahead of competing reqs 0 and 2, then starve[1] returns to 0.
REQ-039 Scenario: all 4 valid, distinct addresses, held 4 cycles -> grant pairs (0,1), (2,3), (0,1), (2,3); rr_ptr sequence 2, 0, 2, 0.
REQ-040 Scenario: grant req 0 addr 9, then rst=1 on the next cycle -> write=0 and no write to register 9; after release, rr_ptr=0.
